// File: rtl/fft_bf_feeder.sv
// fft_bf_feeder: address/control sequencer for an in-place radix-2 DIT FFT driving butterfly_dit
module fft_bf_feeder #(
    parameter int N_LOG2   = 4,
    parameter int WB_DELAY = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr0,
    output logic [N_LOG2-1:0] rd_addr1,
    output logic [N_LOG2-2:0] tw_addr,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr0,
    output logic [N_LOG2-1:0] wr_addr1,
    output logic [N_LOG2-1:0] stage
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
    state_t state, nxt;
    logic phase, hold, last_s, pend, iss;
    logic [N_LOG2-2:0] b, ctw, tw_q;
    logic [N_LOG2-1:0] s, bx, span, pos, ca0, ca1, a0_q, a1_q;
    logic [2*N_LOG2-1:0] tw_w;
    logic [WB_DELAY-1:0] v;
    logic [N_LOG2-1:0] a0p [WB_DELAY];
    logic [N_LOG2-1:0] a1p [WB_DELAY];

    assign last_s = s == N_LOG2'(N_LOG2 - 1);
    // entries still in flight once the oldest one retires on this edge
    assign pend = |v[WB_DELAY-2:0];
    // a new pair is issued on every phase==1 cycle of ISSUE
    assign iss = state == ISSUE && phase;

    // butterfly address arithmetic: a0 = b + (b with the low s bits cleared)
    always_comb begin
        bx   = {1'b0, b};
        span = N_LOG2'(1) << s;
        pos  = bx & (span - 1'b1);
        ca0  = bx + (bx & ~(span - 1'b1));
        ca1  = ca0 + span;
        tw_w = {{N_LOG2{1'b0}}, pos} << (N_LOG2 - 1);
        tw_w = tw_w >> s;
        ctw  = tw_w[N_LOG2-2:0];
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // next state; the final drain skips phase alignment so done follows the last write directly
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = ISSUE;
            ISSUE:   if (hold && &b) nxt = DRAIN;
            DRAIN:   if (!pend && (phase || last_s)) nxt = last_s ? FINISH : ISSUE;
            default: nxt = IDLE;
        endcase
    end

    // outputs; read addresses hold their last value whenever rd_en is low
    always_comb begin
        busy     = state != IDLE;
        done     = state == FINISH;
        rd_en    = state == ISSUE && (phase || hold);
        rd_addr0 = rd_en ? ca0 : a0_q;
        rd_addr1 = rd_en ? ca1 : a1_q;
        tw_addr  = rd_en ? ctw : tw_q;
        wr_en    = v[WB_DELAY-1];
        wr_addr0 = a0p[WB_DELAY-1];
        wr_addr1 = a1p[WB_DELAY-1];
        stage    = s;
    end

    // phase toggle, loop counters, write-back pipeline and address hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
            hold  <= 1'b0;
            s     <= '0;
            b     <= '0;
            v     <= '0;
            a0_q  <= '0;
            a1_q  <= '0;
            tw_q  <= '0;
            for (int i = 0; i < WB_DELAY; i++) begin
                a0p[i] <= '0;
                a1p[i] <= '0;
            end
        end else begin
            phase  <= ~phase;
            hold   <= iss;
            v      <= {v[WB_DELAY-2:0], iss};
            a0p[0] <= rd_addr0;
            a1p[0] <= rd_addr1;
            for (int i = 1; i < WB_DELAY; i++) begin
                a0p[i] <= a0p[i-1];
                a1p[i] <= a1p[i-1];
            end
            a0_q <= rd_addr0;
            a1_q <= rd_addr1;
            tw_q <= tw_addr;
            if (state == IDLE && start) begin
                s <= '0;
                b <= '0;
            end else if (state == ISSUE && hold) begin
                b <= b + 1'b1;
            end else if (state == DRAIN && nxt == ISSUE) begin
                s <= s + 1'b1;
                b <= '0;
            end
        end
    end
endmodule
